// File: rtl/delta_decoder_4bit.sv
// Delta decoder: rebuilds 4-bit samples from (magnitude, sign) deltas against a held reference.
// Optional build macro DELTA_SAT_EN clamps out-of-range results instead of wrapping them.
module delta_decoder_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_load,
  input  logic [3:0] in_mag,
  input  logic       in_sign,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sample,
  output logic       out_ovf,
  output logic       err_nolock
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t     state;
  logic [3:0] ref_q;
  logic [4:0] r;
  logic       ovf;
  logic [3:0] res;
  logic       accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Subtract uses a sign-extended negation, so bit 4 set means ref < mag (borrow);
  // for an add it is the carry out. A zero-magnitude subtract leaves bit 4 clear.
  always_comb begin
    r = '0;
    if (in_sign) r = {1'b0, ref_q} + {1'b1, ~in_mag} + 5'd1;
    else         r = {1'b0, ref_q} + {1'b0, in_mag};
    ovf = r[4];
`ifdef DELTA_SAT_EN
    res = ovf ? (in_sign ? 4'h0 : 4'hF) : r[3:0];
`else
    res = r[3:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ref_q      <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_ovf    <= 1'b0;
      err_nolock <= 1'b0;
    end else if (accept && in_load) begin
      state      <= LOCK;
      ref_q      <= in_mag;
      out_sample <= in_mag;
      out_ovf    <= 1'b0;
      out_valid  <= 1'b1;
    end else if (accept && state == LOCK) begin
      ref_q      <= res;
      out_sample <= res;
      out_ovf    <= ovf;
      out_valid  <= 1'b1;
    end else begin
      // Delta with no reference is swallowed and flagged until reset.
      if (accept) err_nolock <= 1'b1;
      if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_decoder_4bit.sv
// Scoreboard bench for delta_decoder_4bit: driver queues expected samples, monitor checks handoffs.
module tb_delta_decoder_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_load, in_sign;
  logic [3:0] in_mag;
  logic       out_valid, out_ready, out_ovf, err_nolock;
  logic [3:0] out_sample;

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  delta_decoder_4bit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_mag(in_mag), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_ovf(out_ovf), .err_nolock(err_nolock)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Present a token, wait (bounded) for acceptance, queue its expected output.
  task automatic send(input logic ld, input logic [3:0] m, input logic s,
                      input logic push, input logic [3:0] es, input logic eo);
    int n = 0;
    in_valid = 1'b1; in_load = ld; in_mag = m; in_sign = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) exp_q.push_back({es, eo});
    #1 in_valid = 1'b0;
  endtask

  // Monitor: every handoff must match the oldest queued expectation.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_sample", int'(out_sample), int'(e[4:1]));
          chk("out_ovf", int'(out_ovf), int'(e[0]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_load = 1'b1; in_mag = 4'd7; in_sign = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_err_nolock", int'(err_nolock), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Delta before any load: consumed silently, sticky error, still IDLE.
    send(1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("nolock_err", int'(err_nolock), 1);
    chk("nolock_no_out", int'(out_valid), 0);
    send(1'b0, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("idle_still_no_out", int'(out_valid), 0);

    // Load 5, +7, -4 back to back.
    send(1'b1, 4'd5, 1'b0, 1'b1, 4'd5,  1'b0);
    send(1'b0, 4'd7, 1'b0, 1'b1, 4'd12, 1'b0);
    send(1'b0, 4'd4, 1'b1, 1'b1, 4'd8,  1'b0);

    // Load 14, +3, -15.
    send(1'b1, 4'd14, 1'b0, 1'b1, 4'd14, 1'b0);
`ifdef DELTA_SAT_EN
    send(1'b0, 4'd3,  1'b0, 1'b1, 4'd15, 1'b1);
    send(1'b0, 4'd15, 1'b1, 1'b1, 4'd0,  1'b0);
`else
    send(1'b0, 4'd3,  1'b0, 1'b1, 4'd1, 1'b1);
    send(1'b0, 4'd15, 1'b1, 1'b1, 4'd2, 1'b1);
`endif
    @(posedge clk); #1;

    // Backpressure: load 9 then stall with +1 pending.
    out_ready = 1'b0;
    send(1'b1, 4'd9, 1'b0, 1'b1, 4'd9, 1'b0);
    in_valid = 1'b1; in_load = 1'b0; in_mag = 4'd1; in_sign = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_hold_sample", int'(out_sample), 9);
      chk("bp_hold_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1'b0, 4'd1, 1'b0, 1'b1, 4'd10, 1'b0);

    // Same-edge handoff and accept.
    send(1'b1, 4'd6, 1'b0, 1'b1, 4'd6, 1'b0);
    send(1'b0, 4'd6, 1'b1, 1'b1, 4'd0, 1'b0);
    chk("simul_valid", int'(out_valid), 1);
    chk("simul_sample", int'(out_sample), 0);
    @(posedge clk); #1;

    // Asynchronous reset between edges with a pending output.
    out_ready = 1'b0;
    send(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_sample", int'(out_sample), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1'b0, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("post_rst_err", int'(err_nolock), 1);
    chk("post_rst_no_out", int'(out_valid), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
